anton_neopixel_multi: RTL and testbench
=======================================

// Module: anton_neopixel_multi
// PURPOSE
//  Multi-channel successor of the single-string NeoPixel controller: CHANNELS WS2812 strings driven
//  in lockstep from one shared bit/pixel sequencer, each channel from its own byte buffer.
//  Sits between the byte-wide host bus and the LED data pins; bus and stream share one clock.
//  Adds per-channel enable mask, idle state, run-abort and parametrised bit timing.
// PARAMETERS
//  CHANNELS     4    number of strings, 1..8
//  BUFFER_END   255  last byte index of each per-channel buffer; buffer size BUFFER_END+1
//  RESET_DELAY  385  low ticks after a frame (>=50us at 7MHz)
//  BIT_TICKS    8    clock ticks per encoded bit
//  T0H_TICKS    2    high ticks for a 0 bit
//  T1H_TICKS    5    high ticks for a 1 bit, T0H_TICKS < T1H_TICKS < BIT_TICKS
// PORTS
//  clk7mhz     in   1         sole clock (bus and stream)
//  reset       in   1         asynchronous, active-high
//  busAddr     in   14        [13]=0 buffer: {channel, byte}; [13]=1 registers via [2:0]
//  busDataIn   in   8         write data
//  busWrite    in   1         write strobe, sampled at the clk7mhz rising edge
//  busRead     in   1         read strobe
//  busDataOut  out  8         read data, valid 1 cycle after busRead, held until next read
//  neoData     out  CHANNELS  per-string serial data
//  neoState    out  2         sequencer state: 0 IDLE, 1 TRANSMIT, 2 RESET
//  pixelsSync  out  1         high throughout RESET (safe buffer-swap window)
//  irq         out  1         frame-done interrupt (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, ctrl/mask/max = 0, counters 0; buffers not cleared.
//  - Buffer addr: byte = busAddr[BB-1:0], channel = busAddr[BB+CB-1:BB], BB=clog2(BUFFER_END+1),
//    CB=clog2(CHANNELS); BB+CB<=13 (elaboration error otherwise); channel >= CHANNELS: write ignored, read 0.
//  - Regs: 0 max[7:0]; 1 max[12:8]; 2 ctrl {32bit,loop,run,limit,init}; 3 status {irq_pend,reset_st}
//    (RO, bit1 W1C); 4 enable mask[CHANNELS-1:0]; 5-7 read 0, writes ignored.
//  - init: self-clears next cycle; zeroes ctrl/max/mask, forces IDLE, neoData=0; buffers intact.
//  - IDLE -> TRANSMIT on the cycle after run reads 1; pixel index 0, bit 7 of byte 0 first.
//  - Each bit: high T1H/T0H ticks then low to BIT_TICKS; bytes MSB first, ascending address.
//  - 8bit mode: every byte sent, index += 1. 32bit mode: bytes p..p+2 sent, p+3 skipped, p += 4.
//  - last = limit ? max : BUFFER_END (max clipped to BUFFER_END). Frame ends after byte `last`
//    (8bit) or after the pixel with p+4 > last (32bit); then RESET, all neoData low.
//  - RESET lasts exactly RESET_DELAY ticks, then: loop=1 -> TRANSMIT; else run cleared, IDLE.
//  - run written 0 mid-TRANSMIT: current bit abandoned, neoData low next cycle, enter RESET, then IDLE.
//  - Disabled channel (mask bit 0): neoData held 0; mask changes take effect at next byte boundary.
//  - Bus write to ctrl same cycle as frame-end auto-clear of run: bus write wins.
//  - Buffer writes during TRANSMIT permitted; a byte already latched for shifting is unaffected.
//  - Latency: run write -> first neoData rise = 2 cycles.
// CONFIGURATION
//  ANTON_NEOPIXEL_MULTI_IRQ_EN defined: irq_pend set on every RESET->(IDLE|TRANSMIT) transition,
//    irq = irq_pend, cleared by writing 1 to status bit1; set wins over simultaneous clear.
//  Undefined: irq tied 0, status bit1 reads 0, no irq logic synthesised.
// TESTING
//  - reset mid-TRANSMIT -> neoData=0, neoState=0, busDataOut=0 immediately (async).
//  - CH0 byte0=0xA5, limit=1,max=0, mask=1, run -> 8 bits pattern 5,2,5,2,2,5,2,5 high ticks, then 385 low, IDLE, run=0.
//  - 32bit, max=7, bytes 0..7 = 11 22 33 FF 44 55 66 FF -> 48 bits sent (11 22 33 44 55 66), 0xFF never seen.
//  - CHANNELS=4, mask=4'b0101, loop=1 -> ch0/ch2 toggle, ch1/ch3 stay 0; frames repeat back-to-back with 385-tick gaps.
//  - write run=0 at bit 3 of byte 1 -> neoData low next cycle, pixelsSync high 385 ticks, then IDLE.
//  - IRQ_EN: frame end -> irq=1; W1C same cycle as next frame end -> irq stays 1.

Source files
------------

// File: rtl/anton_neopixel_multi.sv
// anton_neopixel_multi: CHANNELS WS2812 strings from one shared bit/pixel sequencer, per-channel byte buffers.
// Optional frame-done interrupt when ANTON_NEOPIXEL_MULTI_IRQ_EN is defined.
module anton_neopixel_multi #(
    parameter int CHANNELS    = 4,
    parameter int BUFFER_END  = 255,
    parameter int RESET_DELAY = 385,
    parameter int BIT_TICKS   = 8,
    parameter int T0H_TICKS   = 2,
    parameter int T1H_TICKS   = 5
) (
    input  logic                clk7mhz,
    input  logic                reset,
    input  logic [13:0]         busAddr,
    input  logic [7:0]          busDataIn,
    input  logic                busWrite,
    input  logic                busRead,
    output logic [7:0]          busDataOut,
    output logic [CHANNELS-1:0] neoData,
    output logic [1:0]          neoState,
    output logic                pixelsSync,
    output logic                irq
);
    localparam int BB  = $clog2(BUFFER_END + 1);
    localparam int CB  = $clog2(CHANNELS);
    localparam int CBW = CB > 0 ? CB : 1;
    localparam int TW  = $clog2(BIT_TICKS);
    localparam int RW  = $clog2(RESET_DELAY + 1);
    localparam logic [TW-1:0] T_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(T1H_TICKS);
    localparam logic [TW-1:0] T_ZERO = TW'(T0H_TICKS);
    localparam logic [RW-1:0] R_LAST = RW'(RESET_DELAY - 1);
    localparam logic [12:0]   BEND   = 13'(BUFFER_END);

    if (BB + CB > 13) begin : g_addr_check
        $error("buffer byte and channel fields do not fit in busAddr[12:0]");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TX = 2'd1, S_RESET = 2'd2} state_t;

    // Buffer is rounded up to a power of two so every byte offset addresses real storage
    logic [7:0]          mem [CHANNELS][2**BB];
    state_t              state, state_d;
    logic [4:0]          ctrl;
    logic [12:0]         max_q, idx, nxt, sel, last_b, a_lo;
    logic [CHANNELS-1:0] mask, ena, nd;
    logic [TW-1:0]       tick;
    logic [2:0]          bit_cnt;
    logic [RW-1:0]       rcnt;
    logic [CBW-1:0]      ch;
    logic [BB-1:0]       boff;
    logic [7:0]          rdata;
    logic                init, limit, run, loop, mode32;
    logic                ch_ok, reg_wr, byte_end, last_byte, frame_end, rst_done, clr_run, load, tx_on, irq_pend;

    assign {mode32, loop, run, limit, init} = ctrl;
    assign a_lo       = busAddr[12:0];
    assign ch         = CBW'(a_lo >> BB);
    assign boff       = busAddr[BB-1:0];
    assign ch_ok      = (a_lo >> BB) < 13'(CHANNELS);
    assign reg_wr     = busWrite && busAddr[13];
    assign last_b     = limit ? (max_q > BEND ? BEND : max_q) : BEND;
    assign byte_end   = tick == T_LAST && bit_cnt == 3'd0;
    assign last_byte  = mode32 ? (idx[1:0] == 2'd2 && {1'b0, idx} + 14'd2 > {1'b0, last_b}) : idx == last_b;
    assign frame_end  = byte_end && last_byte;
    assign nxt        = idx + ((mode32 && idx[1:0] == 2'd2) ? 13'd2 : 13'd1);
    assign rst_done   = rcnt == R_LAST;
    assign clr_run    = state == S_RESET && rst_done && !(loop && run);
    assign load       = state != S_TX && state_d == S_TX;
    assign sel        = load ? 13'd0 : nxt;
    assign tx_on      = state == S_TX && run && !init;
    assign neoState   = state;
    assign pixelsSync = state == S_RESET;

    // Sequencer state register
    always_ff @(posedge clk7mhz or posedge reset)
        if (reset) state <= S_IDLE;
        else state <= state_d;

    // Next state: frame end or run drop go through RESET; init forces IDLE
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = run ? S_TX : S_IDLE;
            S_TX:    state_d = (!run || frame_end) ? S_RESET : S_TX;
            S_RESET: state_d = rst_done ? ((loop && run) ? S_TX : S_IDLE) : S_RESET;
            default: state_d = S_IDLE;
        endcase
        if (init) state_d = S_IDLE;
    end

    // Bit tick, bit counter, byte index and latched channel mask; RESET duration counter
    always_ff @(posedge clk7mhz or posedge reset)
        if (reset) begin
            tick    <= '0;
            bit_cnt <= 3'd7;
            idx     <= 13'd0;
            ena     <= '0;
            rcnt    <= '0;
        end else begin
            rcnt <= state == S_RESET ? rcnt + RW'(1) : '0;
            if (load) begin
                tick    <= '0;
                bit_cnt <= 3'd7;
                idx     <= 13'd0;
                ena     <= mask;
            end else if (state == S_TX) begin
                tick <= tick == T_LAST ? '0 : tick + TW'(1);
                if (tick == T_LAST) bit_cnt <= bit_cnt - 3'd1;
                if (byte_end) begin
                    idx <= nxt;
                    ena <= mask;
                end
            end
        end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0] sh;
        // Per-channel byte shifter, reloaded from the buffer at each byte boundary
        always_ff @(posedge clk7mhz or posedge reset)
            if (reset) sh <= 8'h00;
            else if (load || (state == S_TX && byte_end)) sh <= mem[c][sel[BB-1:0]];
            else if (state == S_TX && tick == T_LAST) sh <= {sh[6:0], 1'b0};
        assign nd[c] = tx_on && ena[c] && tick < (sh[7] ? T_ONE : T_ZERO);
    end

    // Registered line outputs so every string switches on the same edge
    always_ff @(posedge clk7mhz or posedge reset)
        if (reset) neoData <= '0;
        else neoData <= nd;

    // Host writes into the channel buffers; contents survive reset and init
    always_ff @(posedge clk7mhz)
        if (busWrite && !busAddr[13] && ch_ok) mem[ch][boff] <= busDataIn;

    // Control registers; a host write to ctrl beats the frame-end clear of run
    always_ff @(posedge clk7mhz or posedge reset)
        if (reset) begin
            ctrl  <= 5'd0;
            max_q <= 13'd0;
            mask  <= '0;
        end else if (init) begin
            ctrl  <= 5'd0;
            max_q <= 13'd0;
            mask  <= '0;
        end else begin
            if (reg_wr && busAddr[2:0] == 3'd0) max_q[7:0] <= busDataIn;
            if (reg_wr && busAddr[2:0] == 3'd1) max_q[12:8] <= busDataIn[4:0];
            if (reg_wr && busAddr[2:0] == 3'd4) mask <= busDataIn[CHANNELS-1:0];
            ctrl <= (reg_wr && busAddr[2:0] == 3'd2) ? busDataIn[4:0] : clr_run ? (ctrl & 5'b11011) : ctrl;
        end

`ifdef ANTON_NEOPIXEL_MULTI_IRQ_EN
    // Frame-done flag: set on leaving RESET, write-1-to-clear, set wins
    always_ff @(posedge clk7mhz or posedge reset)
        if (reset) irq_pend <= 1'b0;
        else irq_pend <= (state == S_RESET && state_d != S_RESET) ||
                         (irq_pend && !(reg_wr && busAddr[2:0] == 3'd3 && busDataIn[1]));
    assign irq = irq_pend;
`else
    assign irq_pend = 1'b0;
    assign irq      = 1'b0;
`endif

    // Read mux for buffer bytes and registers
    always_comb begin
        rdata = 8'h00;
        if (!busAddr[13]) rdata = ch_ok ? mem[ch][boff] : 8'h00;
        else rdata = busAddr[2:0] == 3'd0 ? max_q[7:0] :
                     busAddr[2:0] == 3'd1 ? {3'b000, max_q[12:8]} :
                     busAddr[2:0] == 3'd2 ? {3'b000, ctrl} :
                     busAddr[2:0] == 3'd3 ? {6'd0, irq_pend, state == S_RESET} :
                     busAddr[2:0] == 3'd4 ? 8'(mask) : 8'h00;
    end

    // Read data is captured on busRead and held until the next read
    always_ff @(posedge clk7mhz or posedge reset)
        if (reset) busDataOut <= 8'h00;
        else if (busRead) busDataOut <= rdata;
endmodule

// File: tb/tb_anton_neopixel_multi.sv
// tb_anton_neopixel_multi: directed self-checking bench for anton_neopixel_multi
module tb_anton_neopixel_multi;
    localparam logic [13:0] R_MAXL = 14'h2000, R_MAXH = 14'h2001, R_CTRL = 14'h2002;
    localparam logic [13:0] R_STAT = 14'h2003, R_MASK = 14'h2004, R_RSV = 14'h2005;

    logic       clk7mhz = 1'b0, reset = 1'b1;
    logic [13:0] busAddr = 14'd0;
    logic [7:0] busDataIn = 8'd0, busDataOut;
    logic       busWrite = 1'b0, busRead = 1'b0;
    logic [3:0] neoData;
    logic [1:0] neoState;
    logic       pixelsSync, irq;
    int checks = 0, failures = 0;

    anton_neopixel_multi dut (
        .clk7mhz(clk7mhz), .reset(reset), .busAddr(busAddr), .busDataIn(busDataIn),
        .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut), .neoData(neoData),
        .neoState(neoState), .pixelsSync(pixelsSync), .irq(irq)
    );

    always #5 clk7mhz = ~clk7mhz;

    // RESET-window length, state entered after RESET, and any activity on masked channels 1/3
    int rs_cur = 0, rs_len = 0, rs_done = 0, hi13 = 0;
    logic [1:0] prev_st = 2'd0, after_rs = 2'd3;
    always @(negedge clk7mhz) begin
        if (pixelsSync) rs_cur++;
        else if (rs_cur != 0) begin
            rs_len = rs_cur;
            rs_cur = 0;
            rs_done++;
        end
        if (prev_st == 2'd2 && neoState != 2'd2) after_rs = neoState;
        prev_st = neoState;
        if (neoData[1] | neoData[3]) hi13++;
    end

    task automatic bus_write(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk7mhz);
        busAddr = a; busDataIn = d; busWrite = 1'b1;
        @(negedge clk7mhz);
        busWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [7:0] d);
        @(negedge clk7mhz);
        busAddr = a; busRead = 1'b1;
        @(negedge clk7mhz);
        busRead = 1'b0;
        d = busDataOut;
    endtask

    task automatic wait_rise(input int c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk7mhz);
            if (neoData[c]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk7mhz);
            if (neoState == s) begin ok = 1'b1; break; end
        end
    endtask

    // Starting at the first high sample of a bit: 8 samples per bit, 5 high = 1, 2 high = 0
    task automatic get_bits(input int c, input int n, output logic [63:0] v, output int bad);
        int cnt;
        v = 64'd0; bad = 0;
        for (int b = 0; b < n; b++) begin
            cnt = 0;
            for (int t = 0; t < 8; t++) begin
                cnt += int'(neoData[c]);
                @(negedge clk7mhz);
            end
            v = {v[62:0], cnt == 5};
            if (cnt != 5 && cnt != 2) bad++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        repeat (3) @(negedge clk7mhz);
        checks++; if ({neoData, neoState, pixelsSync, irq, busDataOut} !== 16'd0) begin failures++;
            $display("FAIL reset_outputs got %h want 0000", {neoData, neoState, pixelsSync, irq, busDataOut}); end
        reset = 1'b0;
        bus_read(R_CTRL, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_ctrl got %h want 00", d); end
    endtask

    task automatic test_regs;
        logic [7:0] d;
        bus_write(14'h0000, 8'hA5);
        bus_write(14'h0305, 8'h3C);
        bus_read(14'h0000, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL buf_ch0 got %h want a5", d); end
        bus_read(14'h0305, d);
        checks++; if (d !== 8'h3C) begin failures++; $display("FAIL buf_ch3 got %h want 3c", d); end
        bus_write(R_MAXH, 8'hFF);
        bus_read(R_MAXH, d);
        checks++; if (d !== 8'h1F) begin failures++; $display("FAIL max_hi got %h want 1f", d); end
        bus_write(R_RSV, 8'h55);
        bus_read(R_RSV, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reg5 got %h want 00", d); end
        bus_write(R_MAXH, 8'h00);
    endtask

    task automatic test_single_byte;
        logic [7:0] d;
        logic [63:0] v;
        int bad;
        bit ok;
        bus_write(R_MASK, 8'h01);
        bus_write(R_MAXL, 8'h00);
        bus_write(R_CTRL, 8'h06);
        checks++; if (neoState !== 2'd0) begin failures++; $display("FAIL lat_idle got %0d want 0", neoState); end
        @(negedge clk7mhz);
        checks++; if (neoState !== 2'd1 || neoData !== 4'h0) begin failures++;
            $display("FAIL lat_tx got state %0d data %h want 1 0", neoState, neoData); end
        @(negedge clk7mhz);
        checks++; if (neoData !== 4'h1) begin failures++; $display("FAIL lat_rise got %h want 1", neoData); end
        get_bits(0, 8, v, bad);
        checks++; if (v[7:0] !== 8'hA5 || bad != 0) begin failures++;
            $display("FAIL byte_a5 got %h bad %0d want a5 bad 0", v[7:0], bad); end
        checks++; if (neoState !== 2'd2 || neoData !== 4'h0) begin failures++;
            $display("FAIL frame_end got state %0d data %h want 2 0", neoState, neoData); end
        bus_read(R_STAT, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL status_reset got %h want 01", d); end
        wait_state(2'd0, ok);
        @(negedge clk7mhz);
        checks++; if (!ok || rs_len != 385 || after_rs !== 2'd0) begin failures++;
            $display("FAIL reset_gap got ok %0d len %0d next %0d want 1 385 0", ok, rs_len, after_rs); end
        bus_read(R_CTRL, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL run_cleared got %h want 02", d); end
        bus_read(R_STAT, d);
`ifdef ANTON_NEOPIXEL_MULTI_IRQ_EN
        checks++; if (d !== 8'h02 || irq !== 1'b1) begin failures++;
            $display("FAIL irq_set got status %h irq %b want 02 1", d, irq); end
        bus_write(R_STAT, 8'h02);
`else
        checks++; if (d !== 8'h00 || irq !== 1'b0) begin failures++;
            $display("FAIL irq_off got status %h irq %b want 00 0", d, irq); end
`endif
    endtask

    task automatic test_mode32;
        logic [7:0] pat [8] = '{8'h11, 8'h22, 8'h33, 8'hFF, 8'h44, 8'h55, 8'h66, 8'hFF};
        logic [63:0] v;
        int bad;
        bit ok;
        for (int i = 0; i < 8; i++) bus_write(14'(i), pat[i]);
        bus_write(R_MAXL, 8'h07);
        bus_write(R_CTRL, 8'h16);
        wait_rise(0, ok);
        get_bits(0, 48, v, bad);
        checks++; if (!ok || v[47:0] !== 48'h112233445566 || bad != 0) begin failures++;
            $display("FAIL mode32 got ok %0d bits %h bad %0d want 1 112233445566 0", ok, v[47:0], bad); end
        checks++; if (neoState !== 2'd2 || neoData !== 4'h0) begin failures++;
            $display("FAIL mode32_end got state %0d data %h want 2 0", neoState, neoData); end
        wait_state(2'd0, ok);
        @(negedge clk7mhz);
        checks++; if (!ok || rs_len != 385) begin failures++;
            $display("FAIL mode32_gap got ok %0d len %0d want 1 385", ok, rs_len); end
    endtask

    task automatic test_mask_loop;
        logic [7:0] d;
        logic [63:0] v;
        int bad, h0;
        bit ok;
        for (int c = 0; c < 4; c++) bus_write(14'(c << 8), 8'(8'h80 | c));
        bus_write(R_MAXL, 8'h00);
        bus_write(R_MASK, 8'h05);
        h0 = hi13;
        bus_write(R_CTRL, 8'h0E);
        wait_rise(0, ok);
        get_bits(0, 8, v, bad);
        checks++; if (!ok || v[7:0] !== 8'h80 || bad != 0) begin failures++;
            $display("FAIL loop_ch0 got ok %0d %h bad %0d want 1 80 0", ok, v[7:0], bad); end
        wait_rise(2, ok);
        get_bits(2, 8, v, bad);
        checks++; if (!ok || v[7:0] !== 8'h82 || bad != 0) begin failures++;
            $display("FAIL loop_ch2 got ok %0d %h bad %0d want 1 82 0", ok, v[7:0], bad); end
        checks++; if (rs_len != 385 || after_rs !== 2'd1) begin failures++;
            $display("FAIL loop_gap got len %0d next %0d want 385 1", rs_len, after_rs); end
`ifdef ANTON_NEOPIXEL_MULTI_IRQ_EN
        wait_state(2'd1, ok);
        bus_write(R_STAT, 8'h02);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got %b want 0", irq); end
        wait_state(2'd2, ok);
        repeat (384) @(negedge clk7mhz);
        busAddr = R_STAT; busDataIn = 8'h02; busWrite = 1'b1;
        @(negedge clk7mhz);
        busWrite = 1'b0;
        checks++; if (irq !== 1'b1 || neoState !== 2'd1) begin failures++;
            $display("FAIL irq_set_wins got irq %b state %0d want 1 1", irq, neoState); end
`endif
        bus_write(R_CTRL, 8'h01);
        @(negedge clk7mhz);
        checks++; if (neoState !== 2'd0 || neoData !== 4'h0) begin failures++;
            $display("FAIL init_stop got state %0d data %h want 0 0", neoState, neoData); end
        bus_read(R_MASK, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL init_mask got %h want 00", d); end
        checks++; if (hi13 != h0) begin failures++; $display("FAIL masked_ch got %0d highs want 0", hi13 - h0); end
    endtask

    task automatic test_abort;
        logic [7:0] d;
        bit ok;
        bus_write(14'h0001, 8'hFF);
        bus_write(R_MASK, 8'h01);
        bus_write(R_CTRL, 8'h04);
        wait_rise(0, ok);
        repeat (88) @(negedge clk7mhz);
        bus_write(R_CTRL, 8'h00);
        checks++; if (!ok || neoData !== 4'h1) begin failures++;
            $display("FAIL abort_pre got ok %0d data %h want 1 1", ok, neoData); end
        @(negedge clk7mhz);
        checks++; if (neoData !== 4'h0 || neoState !== 2'd2) begin failures++;
            $display("FAIL abort_low got data %h state %0d want 0 2", neoData, neoState); end
        wait_state(2'd0, ok);
        @(negedge clk7mhz);
        checks++; if (!ok || rs_len != 385 || after_rs !== 2'd0) begin failures++;
            $display("FAIL abort_gap got ok %0d len %0d next %0d want 1 385 0", ok, rs_len, after_rs); end
        bus_read(R_CTRL, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL abort_ctrl got %h want 00", d); end
    endtask

    task automatic test_async_reset;
        logic [7:0] d;
        bit ok;
        bus_write(R_CTRL, 8'h04);
        bus_read(R_CTRL, d);
        wait_rise(0, ok);
        #2 reset = 1'b1;
        #1;
        checks++; if (!ok || d !== 8'h04 || {neoData, neoState, pixelsSync, busDataOut} !== 15'd0) begin failures++;
            $display("FAIL async_reset got ok %0d rd %h outs %h want 1 04 0000", ok, d, {neoData, neoState, pixelsSync, busDataOut}); end
        @(negedge clk7mhz);
        reset = 1'b0;
        bus_read(R_CTRL, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL async_ctrl got %h want 00", d); end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_single_byte;
        test_mode32;
        test_mask_loop;
        test_abort;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
